// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family.
//   mult_state_e   : control FSM encoding (IDLE, CALC, DONE)
//   MULT_N_DEFAULT : default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam int MULT_N_DEFAULT = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder.sv
// Combinational W-bit ripple-carry adder built from full_adder cells.
//   a, b : W-bit addends
//   sum  : W-bit sum
//   co   : carry out of the top cell
module ripple_carry_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = 1'b0;
  assign co   = c[W];

  full_adder fa [W-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[W-1:0]),
    .s  (sum),
    .co (c[W:1])
  );

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes on acceptance; the sign is
// reapplied when the product is loaded.
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_ready      : operand handshake (a, b, signed_mode)
//   out_valid/out_ready    : result handshake (product, 2N bits)
//   busy                   : high outside IDLE
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(N);
  localparam int W2 = 2 * N;

  mult_state_e     state, state_nxt;
  logic [N-1:0]    mcand, mplr;
  logic            sign_r, smode_r;
  logic [2*N:0]    acc, acc_nxt;
  logic [CW-1:0]   cnt;
  logic            accept, last;
  logic [N-1:0]    a_mag, b_mag;
  logic [N:0]      add_b, sum;
  logic            co;
  logic [2*N-1:0]  res;
  logic            acc_unused;

  // |x| in N-bit unsigned form: the most negative value maps to 2^(N-1).
  assign a_mag = (signed_mode && a[N-1]) ? (~a + N'(1)) : a;
  assign b_mag = (signed_mode && b[N-1]) ? (~b + N'(1)) : b;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(N - 1));

  assign add_b = mplr[cnt] ? {1'b0, mcand} : '0;

  ripple_carry_adder #(.W(N + 1)) u_add (
    .a   (acc[2*N:N]),
    .b   (add_b),
    .sum (sum),
    .co  (co)
  );

  // Add into the upper N+1 bits then shift right; the carry becomes the new
  // top bit and the LSB falls off.
  assign acc_nxt    = {co, sum, acc[N-1:1]};
  assign acc_unused = acc[0];
  assign res        = acc_nxt[2*N-1:0];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      sign_r  <= 1'b0;
      smode_r <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand   <= a_mag;
        mplr    <= b_mag;
        sign_r  <= a[N-1] ^ b[N-1];
        smode_r <= signed_mode;
        acc     <= '0;
        cnt     <= '0;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (last) product <= (smode_r && sign_r) ? (~res + W2'(1)) : res;
      end
    end
  end

endmodule
